// File: rtl/vmask_pkg.sv
// Shared types and constants for the vector mask-reduction sequencer.
package vmask_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic OP_POPC  = 1'b0;
  localparam logic OP_FIRST = 1'b1;

  localparam logic [31:0] FF_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/vmask_tail_mask.sv
// Tail mask for the last mask chunk: keeps bits below vl mod DATA_WIDTH.
// Combinational; all-ones when not the last chunk or when the remainder is zero.
module vmask_tail_mask #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_DW     = $clog2(DATA_WIDTH)
) (
  input  logic [LOG_DW-1:0]     rem_i,
  input  logic                  last_i,
  output logic [DATA_WIDTH-1:0] mask_o
);

  always_comb begin
    mask_o = '1;
    if (last_i && (rem_i != '0)) begin
      mask_o = ~({DATA_WIDTH{1'b1}} << rem_i);
    end
  end

endmodule

// File: rtl/vmask_popc_ctrl.sv
// Mask-reduction sequencer: walks a mask register chunk by chunk, popcounts (or, with
// VMASK_VFIRST_EN, finds the first set bit) and returns a scalar over valid/ready.
module vmask_popc_ctrl
  import vmask_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int VLEN_MAX   = 1024,
  parameter int ADDR_W     = 8,
  parameter int CNT_W      = $clog2(VLEN_MAX) + 1
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  op_i,
  input  logic [CNT_W-1:0]      vl_i,
  input  logic [ADDR_W-1:0]     base_addr_i,
  input  logic                  flush_i,
  output logic                  rd_req_o,
  output logic [ADDR_W-1:0]     rd_addr_o,
  input  logic                  rd_valid_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [31:0]           res_data_o,
  output logic                  busy_o
);

  localparam int LOG_DW = $clog2(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      vl_q, vl_d, idx_q, idx_d, acc_q, acc_d;
  logic [ADDR_W-1:0]     base_q, base_d, rd_addr_q, rd_addr_d;
  logic [31:0]           res_q, res_d;
  logic [CNT_W-1:0]      last_idx;
  logic                  last_chunk;
  logic                  fin;
  logic [31:0]           res_nxt;
  logic [DATA_WIDTH-1:0] tail_mask, chunk;

`ifdef VMASK_VFIRST_EN
  logic op_q, op_d;

  function automatic logic [LOG_DW-1:0] first_set(input logic [DATA_WIDTH-1:0] d);
    first_set = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (d[i]) first_set = LOG_DW'(i);
    end
  endfunction
`else
  logic op_unused;
  assign op_unused = op_i;
`endif

  function automatic logic [CNT_W-1:0] popcnt(input logic [DATA_WIDTH-1:0] d);
    popcnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) popcnt = popcnt + CNT_W'(d[i]);
  endfunction

  assign last_idx   = (vl_q - CNT_W'(1)) >> LOG_DW;
  assign last_chunk = (idx_q == last_idx);

  vmask_tail_mask #(.DATA_WIDTH(DATA_WIDTH), .LOG_DW(LOG_DW)) u_tail (
    .rem_i  (vl_q[LOG_DW-1:0]),
    .last_i (last_chunk),
    .mask_o (tail_mask)
  );

  assign chunk = rd_data_i & tail_mask;

  always_comb begin
    state_d   = state_q;
    vl_d      = vl_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    base_d    = base_q;
    rd_addr_d = rd_addr_q;
    res_d     = res_q;
    fin       = 1'b0;
    res_nxt   = '0;
`ifdef VMASK_VFIRST_EN
    op_d      = op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
`ifdef VMASK_VFIRST_EN
          op_d = op_i;
`endif
          vl_d   = vl_i;
          base_d = base_addr_i;
          idx_d  = '0;
          acc_d  = '0;
          if (vl_i == '0) begin
            state_d = ST_DONE;
            res_d   = '0;
          end else begin
            state_d   = ST_READ;
            rd_addr_d = base_addr_i;
          end
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        if (rd_valid_i) begin
          acc_d   = acc_q + popcnt(chunk);
          fin     = last_chunk;
          res_nxt = 32'(acc_d);
`ifdef VMASK_VFIRST_EN
          // find-first stops at the first chunk holding a set bit
          if (op_q == OP_FIRST) begin
            fin     = last_chunk || (|chunk);
            res_nxt = (|chunk) ? ((32'(idx_q) << LOG_DW) | 32'(first_set(chunk))) : FF_NONE;
          end
`endif
          if (fin) begin
            state_d = ST_DONE;
            res_d   = res_nxt;
          end else begin
            idx_d     = idx_q + CNT_W'(1);
            rd_addr_d = base_q + ADDR_W'(idx_d);
            state_d   = ST_READ;
          end
        end
      end
      ST_DONE: if (res_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= ST_IDLE;
      vl_q      <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      res_q     <= '0;
`ifdef VMASK_VFIRST_EN
      op_q      <= OP_POPC;
`endif
    end else begin
      state_q   <= state_d;
      vl_q      <= vl_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      base_q    <= base_d;
      rd_addr_q <= rd_addr_d;
      res_q     <= res_d;
`ifdef VMASK_VFIRST_EN
      op_q      <= op_d;
`endif
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rd_req_o    = (state_q == ST_READ);
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rd_addr_o   = rd_addr_q;
  assign res_data_o  = res_q;

endmodule

// File: doc/vmask_popc_ctrl.md
# vmask_popc_ctrl

Sequencer for vector mask-reduction instructions (`vcpop.m`, optionally `vfirst.m`) in the vector core. It accepts one request at a time from the vector issue stage. It walks the source mask register in DATA_WIDTH-bit chunks through the register-file read port and masks the tail chunk to `vl`. It popcounts each chunk and returns a scalar result over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 32: mask chunk width per read.
- `VLEN_MAX`, 1024: maximum mask length in bits; must be a multiple of DATA_WIDTH.
- `ADDR_W`, 8: register-file read address width.
- `CNT_W`, `$clog2(VLEN_MAX)+1`: accumulator and `vl` width.
- `clk_i` in 1: single clock, rising edge.
- `resetn_i` in 1: reset, asynchronous and active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `op_i` in 1: 0 = popcount, 1 = find-first.
- `vl_i` in CNT_W: number of mask bits to process, range 0..VLEN_MAX.
- `base_addr_i` in ADDR_W: address of chunk 0 of the mask register.
- `flush_i` in 1: synchronous abort.
- `rd_req_o` out 1: read strobe for one chunk.
- `rd_addr_o` out ADDR_W: `base_addr_i` + chunk index.
- `rd_valid_i` in 1: read data valid.
- `rd_data_i` in DATA_WIDTH: chunk data.
- `res_valid_o` out 1: result valid.
- `res_ready_i` in 1: result consumed.
- `res_data_o` out 32: scalar result.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- States: IDLE, READ, WAIT, DONE.
- IDLE:
  - `req_ready_o`=1.
  - On handshake, latch `op`, `vl` and base address; clear the accumulator and chunk index.
  - If `vl`=0, go to DONE with result 0. Otherwise go to READ.
- READ: assert `rd_req_o` for exactly one cycle with the current chunk address, then go to WAIT.
- WAIT: hold until `rd_valid_i`.
  - Apply the tail mask: in the last chunk, bits at index ≥ (`vl` mod DATA_WIDTH) are forced to 0. No tail mask applies when the remainder is 0.
  - Add the chunk popcount to the accumulator.
  - Go to DONE if this was chunk ceil(`vl`/DATA_WIDTH)−1. Otherwise increment the chunk index and go to READ.
- DONE:
  - `res_valid_o`=1 and `res_data_o` are held stable until `res_ready_i`; the FSM then returns to IDLE.
  - `res_data_o` is the accumulator zero-extended to 32 bits.
- Only one read is outstanding at a time. `rd_valid_i` outside WAIT is ignored.
- `flush_i` takes priority over every other event in every state:
  - Next state is IDLE, and the accumulator and index are cleared.
  - No result is produced and no further reads are issued.
  - A late `rd_valid_i` is ignored.
- The accumulator cannot overflow: CNT_W holds VLEN_MAX.

## Timing
- Reset values:
  - `req_ready_o`=1 (state IDLE).
  - `rd_req_o`, `res_valid_o` and `busy_o` = 0.
  - `rd_addr_o` and `res_data_o` = 0.
- Request accepted on the edge ending cycle t:
  - `rd_req_o` is high in t+1.
  - With 1-cycle read latency, `rd_valid_i` arrives in t+2 and the next `rd_req_o` is in t+3.
- N chunks with 1-cycle latency: `res_valid_o` first high in cycle t+2N+1. `vl`=0: high in t+1.
- Extra read latency adds WAIT cycles one-for-one.
- `req_ready_o` is low from t+1 until the cycle after the result handshake. There is no back-to-back acceptance in DONE.
- Asserting `resetn_i` low at any time returns all state to reset values immediately, including mid-chunk.

## Configuration
- Macro `VMASK_VFIRST_EN`.
- Defined:
  - `op_i`=1 computes find-first: the index of the lowest set bit within `vl`, or 0xFFFF_FFFF if none.
  - The walk stops early: the FSM goes to DONE after the first chunk containing a set bit, and no further reads are issued.
  - A priority-encoder path is compiled in.
- Undefined: `op_i` is ignored and every request performs popcount. The port is kept for interface stability.

## Structure
- Shared package `vmask_pkg`:
  - FSM state enum.
  - `op` encoding constants.
  - Find-first "none" constant 0xFFFF_FFFF.
- One sub-module, `vmask_tail_mask`: combinational tail-mask generation from `vl` mod DATA_WIDTH and a last-chunk flag.
- Popcount and priority encoder live in the top.

## Test plan
- `vl`=32, chunk 0xFFFF_FFFF → `res_data_o`=32; `res_valid_o` in t+3; exactly 1 `rd_req_o`.
- `vl`=40, chunks 0xFFFF_FFFF, 0xFFFF_FFFF → 40. Addresses are base and base+1. The tail masks chunk 1 to 0xFF.
- `vl`=0 → result 0 in t+1 with no `rd_req_o`. Then `res_ready_i` is held low 5 cycles → `res_valid_o` and data stay stable.
- `vl`=128, `flush_i` pulsed in WAIT of chunk 2 → IDLE next cycle with no result. The late `rd_valid_i` is ignored. The next request (`vl`=32, 0x0000_000F) → 4.
- `resetn_i` low mid-READ → all outputs at reset values in the same cycle. After release, `req_ready_o`=1.
- With `VMASK_VFIRST_EN`, find-first:
  - `vl`=64, chunks 0x0, 0x10 → 36.
  - `vl`=64, chunks 0x0, 0x0 → 0xFFFF_FFFF.
  - `vl`=8, chunk 0x100 → 0xFFFF_FFFF, because bit 8 is outside `vl`.
